// File: rtl/traffic_cfg_pkg.sv
// traffic_cfg_pkg: shared definitions for the phase time configuration block.
//   DEFAULT_MIN_TIME / DEFAULT_MAX_TIME : default inclusive edit range in seconds
//   cfg_state_t                         : configuration FSM state encoding
package traffic_cfg_pkg;

  localparam int unsigned DEFAULT_MIN_TIME = 1;
  localparam int unsigned DEFAULT_MAX_TIME = 99;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EDIT,
    CHECK
  } cfg_state_t;

endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for one synchronised level button, with an
// optional hold-to-repeat counter.
//   clk, reset : clock and asynchronous active-high reset
//   btn        : synchronised level button input
//   act        : one-cycle action pulse (rising edge, or auto-repeat tick)
// Build option: CFG_AUTOREPEAT_EN enables the repeat counter for instances with
// AUTO_REPEAT=1. Without it the output is the plain rising edge.
module btn_edge #(
  parameter bit          AUTO_REPEAT   = 1'b0,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic act
);

  logic btn_q;
  logic rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

`ifdef CFG_AUTOREPEAT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        rep_q, rep_d;
  logic        fire;

  // cnt counts cycles since the edge (or since the last repeat); rep marks that
  // the first hold delay has already elapsed.
  always_comb begin
    cnt_d = cnt_q;
    rep_d = rep_q;
    fire  = 1'b0;
    if (!AUTO_REPEAT || !btn) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (rise) begin
      cnt_d = 32'd1;
      rep_d = 1'b0;
    end else if (cnt_q == (rep_q ? REPEAT_CYCLES : HOLD_CYCLES)) begin
      fire  = 1'b1;
      cnt_d = 32'd1;
      rep_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign act = rise | fire;
`else
  logic unused_cfg;
  assign unused_cfg = ^{AUTO_REPEAT, HOLD_CYCLES, REPEAT_CYCLES};
  assign act = rise;
`endif

endmodule

// File: rtl/phase_time_config.sv
// phase_time_config: button-driven editor for traffic light phase durations.
// Loads the running phase times, lets the operator step through phases and
// adjust each one, and commits the edited set only when the red time (phase 0)
// equals the sum of all other phase times.
//   clk, reset      : clock and asynchronous active-high reset
//   enable          : config mode request; dropping it abandons the edit
//   btn_next/inc/dec/confirm : synchronised level buttons (act on rising edge)
//   active_times    : running times, phase k at [k*TIME_W +: TIME_W]
//   modified_times  : last committed times
//   disp_time       : value of the phase being edited (0 when idle)
//   sel_phase       : phase being edited
//   editing         : high while in EDIT
//   confirm_ok/err  : one-cycle result of a confirm
// Build option: CFG_AUTOREPEAT_EN makes held inc/dec repeat after HOLD_CYCLES
// and every REPEAT_CYCLES thereafter.
module phase_time_config
  import traffic_cfg_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = 3,
  parameter int unsigned TIME_W        = 7,
  parameter int unsigned MIN_TIME      = DEFAULT_MIN_TIME,
  parameter int unsigned MAX_TIME      = DEFAULT_MAX_TIME,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  localparam int unsigned SEL_W        = $clog2(NUM_PHASES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         btn_next,
  input  logic                         btn_inc,
  input  logic                         btn_dec,
  input  logic                         btn_confirm,
  input  logic [NUM_PHASES*TIME_W-1:0] active_times,
  output logic [NUM_PHASES*TIME_W-1:0] modified_times,
  output logic [TIME_W-1:0]            disp_time,
  output logic [SEL_W-1:0]             sel_phase,
  output logic                         editing,
  output logic                         confirm_ok,
  output logic                         confirm_err
);

  localparam int unsigned SUM_W = TIME_W + $clog2(NUM_PHASES);
  localparam logic [TIME_W-1:0] MIN_T = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(NUM_PHASES - 1);

  cfg_state_t                  state_q, state_d;
  logic [TIME_W-1:0]           temp_q [NUM_PHASES];
  logic [TIME_W-1:0]           temp_d [NUM_PHASES];
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [NUM_PHASES*TIME_W-1:0] mod_q, mod_d;
  logic [SUM_W-1:0]            sum;
  logic                        sum_ok;
  logic                        act_next, act_inc, act_dec, act_confirm;

  btn_edge #(.AUTO_REPEAT(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_next (.clk(clk), .reset(reset), .btn(btn_next), .act(act_next));
  btn_edge #(.AUTO_REPEAT(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_inc (.clk(clk), .reset(reset), .btn(btn_inc), .act(act_inc));
  btn_edge #(.AUTO_REPEAT(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_dec (.clk(clk), .reset(reset), .btn(btn_dec), .act(act_dec));
  btn_edge #(.AUTO_REPEAT(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_confirm (.clk(clk), .reset(reset), .btn(btn_confirm), .act(act_confirm));

  function automatic logic [TIME_W-1:0] clamp(input logic [TIME_W-1:0] v);
    if (v < MIN_T)      return MIN_T;
    else if (v > MAX_T) return MAX_T;
    else                return v;
  endfunction

  // Sum is widened so that N-1 phases at full scale cannot overflow.
  always_comb begin
    sum = '0;
    for (int k = 1; k < NUM_PHASES; k++) sum = sum + SUM_W'(temp_q[k]);
  end
  assign sum_ok = (SUM_W'(temp_q[0]) == sum);

  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    sel_d   = sel_q;
    mod_d   = mod_q;
    if (!enable) begin
      state_d = IDLE;
      sel_d   = '0;
      for (int k = 0; k < NUM_PHASES; k++) temp_d[k] = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          for (int k = 0; k < NUM_PHASES; k++) begin
            temp_d[k] = clamp(active_times[k*TIME_W +: TIME_W]);
          end
          mod_d   = active_times;
          sel_d   = '0;
          state_d = EDIT;
        end
        EDIT: begin
          // Priority confirm > next > inc > dec; losing edges are dropped.
          if (act_confirm) begin
            state_d = CHECK;
          end else if (act_next) begin
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
          end else if (act_inc) begin
            temp_d[sel_q] = (temp_q[sel_q] >= MAX_T) ? MIN_T : temp_q[sel_q] + TIME_W'(1);
          end else if (act_dec) begin
            temp_d[sel_q] = (temp_q[sel_q] <= MIN_T) ? MAX_T : temp_q[sel_q] - TIME_W'(1);
          end
        end
        CHECK: begin
          state_d = EDIT;
          if (sum_ok) begin
            for (int k = 0; k < NUM_PHASES; k++) mod_d[k*TIME_W +: TIME_W] = temp_q[k];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mod_q   <= '0;
      for (int k = 0; k < NUM_PHASES; k++) temp_q[k] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mod_q   <= mod_d;
      temp_q  <= temp_d;
    end
  end

  always_comb begin
    editing        = (state_q == EDIT);
    disp_time      = ((state_q == EDIT) || (state_q == CHECK)) ? temp_q[sel_q] : '0;
    // A CHECK cut short by enable dropping neither commits nor reports.
    confirm_ok     = (state_q == CHECK) && enable && sum_ok;
    confirm_err    = (state_q == CHECK) && enable && !sum_ok;
    sel_phase      = sel_q;
    modified_times = mod_q;
  end

endmodule

// File: doc/phase_time_config.md
PHASE_TIME_CONFIG -- requirements
Module: phase_time_config

Interface
REQ-001 The block SHALL have parameter NUM_PHASES, default 3, meaning number of light phases (phase 0 = red, 1..N-1 = green, yellow, ...); legal range 2..8.
REQ-002 The block SHALL have parameter TIME_W, default 7, meaning width of one phase time in seconds.
REQ-003 The block SHALL have parameter MIN_TIME, default 1, and MAX_TIME, default 99, meaning the inclusive legal edit range.
REQ-004 The block SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-005 The block SHALL have ports: enable  in  1  config mode request; btn_next, btn_inc, btn_dec, btn_confirm  in  1 each  synchronised level buttons.
REQ-006 The block SHALL have port active_times  in  NUM_PHASES*TIME_W  current times, phase k at bits [k*TIME_W +: TIME_W].
REQ-007 The block SHALL have ports: modified_times  out  NUM_PHASES*TIME_W  committed times; disp_time  out  TIME_W  value shown on both lane displays; sel_phase  out  $clog2(NUM_PHASES)  phase being edited; editing  out  1  FSM in EDIT; confirm_ok, confirm_err  out  1 each  one-cycle result pulses.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD, EDIT, CHECK, all transitions on posedge clk.
REQ-009 IDLE->LOAD on enable=1; LOAD copies active_times into temp and modified_times, sets sel_phase=0, then goes to EDIT unconditionally (one cycle).
REQ-010 Buttons SHALL act only on rising edge (high this cycle, low last cycle); a held button acts once.
REQ-011 In EDIT, simultaneous edges SHALL resolve confirm > next > inc > dec; lower-priority edges in that cycle are dropped.
REQ-012 next SHALL advance sel_phase by 1, wrapping NUM_PHASES-1 -> 0.
REQ-013 inc SHALL add 1 to temp[sel_phase]; at MAX_TIME it wraps to MIN_TIME.
REQ-014 dec SHALL subtract 1 from temp[sel_phase]; at MIN_TIME it wraps to MAX_TIME.
REQ-015 disp_time SHALL equal temp[sel_phase] in EDIT/CHECK, 0 in IDLE; updated the cycle after the acting edge.
REQ-016 confirm SHALL move EDIT->CHECK; CHECK lasts one cycle then returns to EDIT.
REQ-017 In CHECK, if temp[0] equals the sum of temp[1..N-1] (sum computed in TIME_W+$clog2(NUM_PHASES) bits, no truncation), all temps SHALL be copied to modified_times and confirm_ok pulsed; otherwise modified_times unchanged and confirm_err pulsed.
REQ-018 enable=0 in any state SHALL force IDLE next cycle; temps discarded, modified_times retained.
REQ-019 Temp values outside MIN..MAX loaded in LOAD SHALL be clamped to the nearest bound.

Reset
REQ-020 reset SHALL asynchronously force IDLE, sel_phase=0, disp_time=0, modified_times=0, temps=0, editing=0, confirm_ok=0, confirm_err=0, edge registers=0.
REQ-021 Reset asserted mid-edit SHALL discard all edits with no pulse emitted.

Configuration
REQ-022 With macro CFG_AUTOREPEAT_EN defined, inc/dec held continuously SHALL repeat after HOLD_CYCLES (parameter, default 50_000_000) and every REPEAT_CYCLES (default 10_000_000) thereafter, same wrap rules.
REQ-023 Without CFG_AUTOREPEAT_EN, HOLD_CYCLES/REPEAT_CYCLES SHALL be unused and behaviour is strictly edge-only per REQ-010.

Structure
REQ-024 Package traffic_cfg_pkg SHALL hold MIN_TIME/MAX_TIME defaults and the cfg_state_t enum (IDLE, LOAD, EDIT, CHECK).
REQ-025 Sub-module btn_edge (one instance per button: edge detect plus optional auto-repeat counter) SHALL be used.

Verification
REQ-026 Reset, enable=1 with active_times {Y=3,G=27,R=30}: after 2 cycles editing=1, sel_phase=0, disp_time=30.
REQ-027 Phase 0 at 99, one inc edge -> disp_time=1; one dec edge -> 99.
REQ-028 R=30, next, inc G to 28, confirm -> confirm_err pulse, modified_times unchanged; inc R to 31, confirm -> confirm_ok, modified R=31, G=28, Y=3.
REQ-029 inc and dec edges same cycle from 30 -> 31; confirm plus inc same cycle -> CHECK, value unchanged.
REQ-030 enable dropped after an edit -> IDLE next cycle, disp_time=0, modified_times keep the last committed values.
REQ-031 NUM_PHASES=4, three next edges -> sel_phase=3; fourth -> 0.
